// File: rtl/mcu_link_pkg.sv
// Shared types for the SWPD MCU link sequencer: FSM states, result status codes
// and a small width helper.
package mcu_link_pkg;

  localparam int STATUS_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_ACK,
    RECV,
    DONE
  } state_t;

  typedef enum logic [STATUS_W-1:0] {
    OK      = 2'b00,
    TIMEOUT = 2'b01,
    PARITY  = 2'b10
  } status_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mcu_link_sync.sv
// Two-flop synchronizer bank for the asynchronous MCU lines (one chain per bit).
module mcu_link_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk) begin
        if (rst) begin
          r_meta[gi] <= 1'b0;
          r_sync[gi] <= 1'b0;
        end else begin
          r_meta[gi] <= i_async[gi];
          r_sync[gi] <= r_meta[gi];
        end
      end
    end
  endgenerate

  assign o_sync = r_sync;

endmodule

// File: rtl/mcu_link_sequencer.sv
// SWPD MCU link transaction controller: command out, bounded ack wait, optional
// response in. Define MCU_LINK_PARITY_EN to append/check an odd-parity bit.
module mcu_link_sequencer
  import mcu_link_pkg::*;
#(
  parameter int CMD_BITS    = 8,
  parameter int RSP_BITS    = 16,
  parameter int ACK_TIMEOUT = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CMD_BITS-1:0] req_cmd,
  input  logic                req_expect_rsp,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [RSP_BITS-1:0] rsp_data,
  output logic [STATUS_W-1:0] rsp_status,
  output logic                busy,
  output logic                mcu_clk_enable,
  output logic                wait_reset,
  input  logic                wait_done,
  input  logic                mcu_clk_send,
  input  logic                mcu_clk_recv,
  output logic                mcu_sdo,
  input  logic                mcu_sdi,
  input  logic                mcu_ack
);

`ifdef MCU_LINK_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int CMD_LEN = CMD_BITS + PAR_BITS;
  localparam int RSP_LEN = RSP_BITS + PAR_BITS;
  localparam int CNT_W   = $clog2(max_int(CMD_BITS, RSP_BITS) + 1) + 1;
  localparam int RTY_W   = $clog2(ACK_TIMEOUT + 1);

  state_t              r_state;
  logic                r_req_ready;
  logic                r_rsp_valid;
  logic [RSP_BITS-1:0] r_rsp_data;
  status_t             r_rsp_status;
  logic                r_busy;
  logic                r_clk_en;
  logic                r_wait_reset;
  logic                r_sdo;
  logic                r_expect;
  logic [CMD_LEN-1:0]  r_cmd_shift;
  logic [RSP_LEN-1:0]  r_rsp_shift;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [RTY_W-1:0]    r_retry;

  logic [1:0]          w_sync;
  logic                w_ack_s;
  logic                w_sdi_s;
  logic [CMD_LEN-1:0]  w_cmd_load;
  logic [CMD_LEN-1:0]  w_cmd_shifted;
  logic [RSP_LEN-1:0]  w_rsp_next;
  logic [CNT_W-1:0]    w_bit_cnt_inc;
  logic [RTY_W-1:0]    w_retry_inc;
  logic                w_rsp_par_ok;

  mcu_link_sync #(.WIDTH(2)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async ({mcu_ack, mcu_sdi}),
    .o_sync  (w_sync)
  );

  assign w_ack_s = w_sync[1];
  assign w_sdi_s = w_sync[0];

`ifdef MCU_LINK_PARITY_EN
  // Odd parity: data plus parity bit always carries an odd number of ones.
  assign w_cmd_load   = {req_cmd, ~^req_cmd};
  assign w_rsp_par_ok = ^w_rsp_next;
`else
  assign w_cmd_load   = req_cmd;
  assign w_rsp_par_ok = 1'b1;
`endif

  assign w_cmd_shifted = r_cmd_shift << 1;
  assign w_rsp_next    = (r_rsp_shift << 1) | RSP_LEN'(w_sdi_s);
  assign w_bit_cnt_inc = r_bit_cnt + 1'b1;
  assign w_retry_inc   = r_retry + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_req_ready  <= 1'b1;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_status <= OK;
      r_busy       <= 1'b0;
      r_clk_en     <= 1'b0;
      r_wait_reset <= 1'b0;
      r_sdo        <= 1'b0;
      r_expect     <= 1'b0;
      r_cmd_shift  <= '0;
      r_rsp_shift  <= '0;
      r_bit_cnt    <= '0;
      r_retry      <= '0;
    end else begin
      r_wait_reset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid && r_req_ready) begin
            r_cmd_shift <= w_cmd_load;
            r_expect    <= req_expect_rsp;
            r_sdo       <= w_cmd_load[CMD_LEN-1];
            r_bit_cnt   <= '0;
            r_req_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_clk_en    <= 1'b1;
            r_state     <= SEND;
          end
        end
        SEND: begin
          if (mcu_clk_send) begin
            r_cmd_shift <= w_cmd_shifted;
            r_bit_cnt   <= w_bit_cnt_inc;
            if (w_bit_cnt_inc == CNT_W'(CMD_LEN)) begin
              r_sdo        <= 1'b0;
              r_retry      <= '0;
              r_wait_reset <= 1'b1;
              r_state      <= WAIT_ACK;
            end else begin
              r_sdo <= w_cmd_shifted[CMD_LEN-1];
            end
          end
        end
        WAIT_ACK: begin
          if (mcu_clk_recv && w_ack_s) begin
            r_bit_cnt   <= '0;
            r_rsp_shift <= '0;
            if (r_expect) begin
              r_state <= RECV;
            end else begin
              r_state      <= DONE;
              r_clk_en     <= 1'b0;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= OK;
              r_rsp_data   <= '0;
            end
          // wait_done may still read high while our restart pulse is in flight
          end else if (wait_done && !r_wait_reset) begin
            r_wait_reset <= 1'b1;
            r_retry      <= w_retry_inc;
            if (w_retry_inc == RTY_W'(ACK_TIMEOUT)) begin
              r_state      <= DONE;
              r_clk_en     <= 1'b0;
              r_rsp_valid  <= 1'b1;
              r_rsp_status <= TIMEOUT;
              r_rsp_data   <= '0;
            end
          end
        end
        RECV: begin
          if (mcu_clk_recv) begin
            r_rsp_shift <= w_rsp_next;
            r_bit_cnt   <= w_bit_cnt_inc;
            if (w_bit_cnt_inc == CNT_W'(RSP_LEN)) begin
              r_state     <= DONE;
              r_clk_en    <= 1'b0;
              r_rsp_valid <= 1'b1;
              if (w_rsp_par_ok) begin
                r_rsp_status <= OK;
                r_rsp_data   <= w_rsp_next[RSP_LEN-1 -: RSP_BITS];
              end else begin
                r_rsp_status <= PARITY;
                r_rsp_data   <= '0;
              end
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_data       = r_rsp_data;
  assign rsp_status     = r_rsp_status;
  assign busy           = r_busy;
  assign mcu_clk_enable = r_clk_en;
  assign wait_reset     = r_wait_reset;
  assign mcu_sdo        = r_sdo;

endmodule

// File: tb/tb_mcu_link_sequencer.sv
// Directed bench for mcu_link_sequencer with a behavioural MCU/clock-generator model.
// Honours MCU_LINK_PARITY_EN the same way as the design.
module tb_mcu_link_sequencer;

  localparam int CMD_BITS    = 8;
  localparam int RSP_BITS    = 16;
  localparam int ACK_TIMEOUT = 3;
`ifdef MCU_LINK_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int CMD_LEN = CMD_BITS + PAR;
  localparam int RSP_LEN = RSP_BITS + PAR;
  localparam int WIN     = 20;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                req_valid = 1'b0;
  logic                req_ready;
  logic [CMD_BITS-1:0] req_cmd = '0;
  logic                req_expect_rsp = 1'b0;
  logic                rsp_valid;
  logic                rsp_ready = 1'b0;
  logic [RSP_BITS-1:0] rsp_data;
  logic [1:0]          rsp_status;
  logic                busy;
  logic                mcu_clk_enable;
  logic                wait_reset;
  logic                wait_done = 1'b0;
  logic                mcu_clk_send = 1'b0;
  logic                mcu_clk_recv = 1'b0;
  logic                mcu_sdo;
  logic                mcu_sdi = 1'b0;
  logic                mcu_ack = 1'b0;

  int checks = 0;
  int failures = 0;

  // MCU / clock generator model state
  int                 phase = 0;
  int                 sends = 0;
  int                 wd_cnt = 0;
  int                 wr_pulses = 0;
  logic [CMD_LEN-1:0] cap_sdo = '0;
  logic [RSP_LEN-1:0] mdl_rsp = '0;
  logic               mdl_ack = 1'b0;

  always #5 clk = ~clk;

  mcu_link_sequencer #(
    .CMD_BITS    (CMD_BITS),
    .RSP_BITS    (RSP_BITS),
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_expect_rsp (req_expect_rsp),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_status     (rsp_status),
    .busy           (busy),
    .mcu_clk_enable (mcu_clk_enable),
    .wait_reset     (wait_reset),
    .wait_done      (wait_done),
    .mcu_clk_send   (mcu_clk_send),
    .mcu_clk_recv   (mcu_clk_recv),
    .mcu_sdo        (mcu_sdo),
    .mcu_sdi        (mcu_sdi),
    .mcu_ack        (mcu_ack)
  );

  // Send strobe at phase 2, recv at phase 6 of an 8-cycle MCU period; phase restarts when disabled.
  always @(negedge clk) begin
    if (wait_reset) wr_pulses++;
    if (rst || !mcu_clk_enable) begin
      phase = 0;
      sends = 0;
      mcu_clk_send = 1'b0;
      mcu_clk_recv = 1'b0;
    end else begin
      phase = (phase + 1) % 8;
      mcu_clk_send = (phase == 2);
      mcu_clk_recv = (phase == 6);
      if (mcu_clk_send) begin
        if (sends < CMD_LEN) cap_sdo = {cap_sdo[CMD_LEN-2:0], mcu_sdo};
        else if (sends - CMD_LEN < RSP_LEN) mcu_sdi = mdl_rsp[RSP_LEN-1-(sends-CMD_LEN)];
        sends++;
      end
    end
    mcu_ack = mdl_ack;
    if (rst || wait_reset || !mcu_clk_enable) begin
      wd_cnt = 0;
      wait_done = 1'b0;
    end else begin
      wd_cnt++;
      if (wd_cnt >= WIN) wait_done = 1'b1;
    end
  end

  function automatic logic [CMD_LEN-1:0] cmd_bits(input logic [CMD_BITS-1:0] c);
`ifdef MCU_LINK_PARITY_EN
    return {c, ~^c};
`else
    return c;
`endif
  endfunction

  function automatic logic [RSP_LEN-1:0] rsp_bits(input logic [RSP_BITS-1:0] w);
`ifdef MCU_LINK_PARITY_EN
    return {w, ~^w};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [CMD_BITS-1:0] cmd, input logic exp_rsp, input logic ack);
    mdl_ack        = ack;
    req_cmd        = cmd;
    req_expect_rsp = exp_rsp;
    req_valid      = 1'b1;
    @(negedge clk);
    req_valid      = 1'b0;
  endtask

  task automatic wait_rsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
    $display("txn %s status=%0d data=0x%04h", tag, rsp_status, rsp_data);
  endtask

  task automatic consume(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int base;
    int n;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_status", 32'(rsp_status), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_clk_en", 32'(mcu_clk_enable), 32'd0);
    check("rst_wait_reset", 32'(wait_reset), 32'd0);
    check("rst_sdo", 32'(mcu_sdo), 32'd0);

    // Command 0xA5, no response, MCU acks at the first recv after the command
    base = wr_pulses;
    issue(8'hA5, 1'b0, 1'b1);
    check("a5_busy", 32'(busy), 32'd1);
    check("a5_req_ready", 32'(req_ready), 32'd0);
    wait_rsp("a5");
    check("a5_sdo_seq", 32'(cap_sdo), 32'(cmd_bits(8'hA5)));
    check("a5_status", 32'(rsp_status), 32'd0);
    check("a5_data", 32'(rsp_data), 32'd0);
    check("a5_clk_en", 32'(mcu_clk_enable), 32'd0);
    @(negedge clk);
    check("a5_wr_pulses", 32'(wr_pulses - base), 32'd1);
    consume("a5");

    // Command 0x3C with 0xBEEF response
    mdl_rsp = rsp_bits(16'hBEEF);
    issue(8'h3C, 1'b1, 1'b1);
    wait_rsp("3c");
    check("3c_sdo_seq", 32'(cap_sdo), 32'(cmd_bits(8'h3C)));
    check("3c_data", 32'(rsp_data), 32'h0000BEEF);
    check("3c_status", 32'(rsp_status), 32'd0);
    check("3c_clk_en", 32'(mcu_clk_enable), 32'd0);
    consume("3c");

    // Ack never arrives: entry pulse plus one per expired window, timeout on the third
    base = wr_pulses;
    issue(8'h81, 1'b1, 1'b0);
    wait_rsp("tmo");
    @(negedge clk);
    check("tmo_wr_pulses", 32'(wr_pulses - base), 32'd4);
    check("tmo_status", 32'(rsp_status), 32'd1);
    check("tmo_data", 32'(rsp_data), 32'd0);
    check("tmo_clk_en", 32'(mcu_clk_enable), 32'd0);
    consume("tmo");

    // Result held for 50 cycles while a second request is offered
    mdl_rsp = rsp_bits(16'h1234);
    issue(8'h3C, 1'b1, 1'b1);
    wait_rsp("hold");
    req_cmd   = 8'h77;
    req_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'h00001234);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    consume("hold");
    repeat (5) @(negedge clk);
    check("hold_not_accepted", 32'(busy), 32'd0);

    // Reset while the eighth response bit is on the wire
    mdl_rsp = rsp_bits(16'hA5C3);
    issue(8'h5A, 1'b1, 1'b1);
    n = 0;
    while (sends < CMD_LEN + 8 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reached_bit7", 32'(sends >= CMD_LEN + 8), 32'd1);
    check("mid_in_recv", 32'(busy), 32'd1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_req_ready", 32'(req_ready), 32'd1);
    check("mid_clk_en", 32'(mcu_clk_enable), 32'd0);
    check("mid_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (20) @(negedge clk);
    check("mid_no_rsp", 32'(rsp_valid), 32'd0);
    issue(8'h11, 1'b0, 1'b1);
    wait_rsp("11");
    check("11_sdo_seq", 32'(cap_sdo), 32'(cmd_bits(8'h11)));
    check("11_status", 32'(rsp_status), 32'd0);
    consume("11");

`ifdef MCU_LINK_PARITY_EN
    // Response 0x0001 already odd, so a parity bit of 1 is wrong
    mdl_rsp = {16'h0001, 1'b1};
    issue(8'h42, 1'b1, 1'b1);
    wait_rsp("par");
    check("par_status", 32'(rsp_status), 32'd2);
    check("par_data", 32'(rsp_data), 32'd0);
    consume("par");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
